// File: rtl/scan_sequencer_3x8_if.sv
// Control/status bundle between a scan controller and the channel sequencer.
// The master side issues start/stop and scan setup; the slave drives the decoder select.
interface scan_sequencer_3x8_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         mask;
  logic [2:0]         sel;
  logic               en;
  logic               busy;
  logic               wrap;
  logic               done;

  modport master (
    output start, stop, continuous, dwell, mask,
    input  sel, en, busy, wrap, done
  );

  modport slave (
    input  start, stop, continuous, dwell, mask,
    output sel, en, busy, wrap, done
  );
endinterface

// File: rtl/scan_sequencer_3x8.sv
// Round-robin scanner for a 3x8 decoder: masked channels, dwell slots,
// one blanking cycle between channels, one-shot or continuous passes.
module scan_sequencer_3x8 #(
  parameter int DWELL_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  scan_sequencer_3x8_if.slave  sq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         mask_q, mask_d;
  logic               mode_q, mode_d;
  logic [2:0]         sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;

  logic               nxt_hit;
  logic [2:0]         nxt_idx;
  logic               start_ok;
  logic               pass_end;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Priority search strictly above sel; no wrap-around within a pass
  always_comb begin
    nxt_hit = 1'b0;
    nxt_idx = '0;
    for (int i = 7; i >= 1; i--) begin
      if (mask_q[i] && (3'(i) > sel_q)) begin
        nxt_hit = 1'b1;
        nxt_idx = 3'(i);
      end
    end
  end

  assign start_ok = sq.start && !sq.stop && (|sq.mask);
  assign pass_end = (state_q == BLANK) && !sq.stop && !nxt_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start_ok) begin
          state_d = ACTIVE;
          mode_d  = sq.continuous;
          dwell_d = sq.dwell;
          mask_d  = sq.mask;
          sel_d   = lowest(sq.mask);
          cnt_d   = sq.dwell;
        end
      end
      (state_q == ACTIVE): begin
        if (sq.stop)
          state_d = IDLE;
        else if (cnt_q == '0)
          state_d = BLANK;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: begin
        if (sq.stop) begin
          state_d = IDLE;
        end else if (nxt_hit) begin
          state_d = ACTIVE;
          sel_d   = nxt_idx;
          cnt_d   = dwell_q;
        end else if (mode_q) begin
          state_d = ACTIVE;
          sel_d   = lowest(mask_q);
          cnt_d   = dwell_q;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    en_d   = (state_d == ACTIVE);
    busy_d = (state_d != IDLE);
    wrap_d = pass_end;
    done_d = pass_end && !mode_q;
  end

  assign sq.sel  = sel_q;
  assign sq.en   = en_q;
  assign sq.busy = busy_q;
  assign sq.wrap = wrap_q;
  assign sq.done = done_q;

endmodule

// File: tb/tb_scan_sequencer_3x8.sv
// Scoreboard bench: a pass-level model predicts every output cycle,
// a negedge monitor compares the DUT against the queued predictions.
module tb_scan_sequencer_3x8;

  typedef struct packed {
    int unsigned cyc;
    logic [2:0]  sel;
    logic        en;
    logic        busy;
    logic        wrap;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  exp_t        sb[$];
  exp_t        plan[$];
  exp_t        cur;
  exp_t        mon_e;
  logic        mode_m;
  logic [7:0]  dwell_m;
  logic [7:0]  mask_m;

  scan_sequencer_3x8_if #(.DWELL_W(8)) sq ();

  scan_sequencer_3x8 #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (sq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // One pass: every enabled channel gets dwell+1 enabled cycles then a blank
  task automatic gen_pass(input bit wrap_first);
    exp_t e;
    bit   first;
    logic [2:0] last;
    first = wrap_first;
    last  = '0;
    for (int k = 0; k < 8; k++) begin
      if (mask_m[k]) begin
        for (int d = 0; d <= int'(dwell_m); d++) begin
          e = '0;
          e.sel = 3'(k); e.en = 1'b1; e.busy = 1'b1;
          e.wrap = first;
          first = 1'b0;
          plan.push_back(e);
        end
        e = '0;
        e.sel = 3'(k); e.busy = 1'b1;
        plan.push_back(e);
        last = 3'(k);
      end
    end
    if (!mode_m) begin
      e = '0;
      e.sel = last; e.wrap = 1'b1; e.done = 1'b1;
      plan.push_back(e);
    end
  endtask

  task automatic model(input logic st, input logic sp, input logic ct,
                       input logic [7:0] dw, input logic [7:0] mk);
    exp_t n;
    n = '0;
    n.sel = cur.sel;
    if (cur.busy) begin
      if (sp) begin
        plan.delete();
      end else begin
        if (plan.size() == 0) gen_pass(1'b1);
        n = plan.pop_front();
      end
    end else if (st && !sp && (mk != 8'h00)) begin
      mode_m  = ct;
      dwell_m = dw;
      mask_m  = mk;
      plan.delete();
      gen_pass(1'b0);
      n = plan.pop_front();
    end
    n.cyc = cyc + 1;
    sb.push_back(n);
    cur = n;
  endtask

  task automatic step(input logic st, input logic sp, input logic ct,
                      input logic [7:0] dw, input logic [7:0] mk);
    @(posedge clk);
    #1;
    sq.start      = st;
    sq.stop       = sp;
    sq.continuous = ct;
    sq.dwell      = dw;
    sq.mask       = mk;
    model(st, sp, ct, dw, mk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
  endtask

  task automatic model_reset();
    cur     = '0;
    plan.delete();
    mode_m  = 1'b0;
    dwell_m = '0;
    mask_m  = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sel"},  int'(sq.sel),  0);
    chk({tag, "_en"},   int'(sq.en),   0);
    chk({tag, "_busy"}, int'(sq.busy), 0);
    chk({tag, "_wrap"}, int'(sq.wrap), 0);
    chk({tag, "_done"}, int'(sq.done), 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    sq.start = 1'b0;
    sq.stop  = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    #1;
    check_zero("async_rst");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (rst_n && sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc ||
          sq.sel != mon_e.sel || sq.en != mon_e.en ||
          sq.busy != mon_e.busy || sq.wrap != mon_e.wrap ||
          sq.done != mon_e.done) begin
        errors++;
        $display("FAIL trace cyc=%0d/%0d got sel=%0d en=%0b busy=%0b wrap=%0b done=%0b want sel=%0d en=%0b busy=%0b wrap=%0b done=%0b",
                 cyc, mon_e.cyc, sq.sel, sq.en, sq.busy, sq.wrap, sq.done,
                 mon_e.sel, mon_e.en, mon_e.busy, mon_e.wrap, mon_e.done);
      end
    end
  end

  initial begin
    sq.start      = 1'b0;
    sq.stop       = 1'b0;
    sq.continuous = 1'b0;
    sq.dwell      = '0;
    sq.mask       = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(4);

    // Full one-shot scan, dwell 0, all channels
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'hFF);
    idle(20);

    // Masked one-shot, mask changed mid-scan
    step(1'b1, 1'b0, 1'b0, 8'd2, 8'hA4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'd7, 8'hA4);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 8'd7, 8'hFF);

    // Continuous single channel, then stop
    step(1'b1, 1'b0, 1'b1, 8'd1, 8'h01);
    idle(11);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
    idle(4);

    // Ignored requests
    step(1'b1, 1'b0, 1'b1, 8'd1, 8'h00);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 8'd0, 8'hFF);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'hFF);
    idle(3);
    step(1'b1, 1'b0, 1'b1, 8'd0, 8'h80);
    idle(6);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
    idle(2);

    // Stop landing on the final blank of a one-shot
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'h10);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
    idle(4);

    // Async reset in the middle of an active slot
    step(1'b1, 1'b0, 1'b1, 8'd3, 8'hFF);
    idle(2);
    async_reset();
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] mk;
      mk = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 3)),
           mk);
    end
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
    idle(2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
